// File: rtl/pcm_mm_arbiter.sv
// rtl/pcm_mm_arbiter.sv - N-channel CPU arbiter in front of the pcm_mem_mm slave port
// Define PCM_MM_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest requesting channel wins.
module pcm_mm_arbiter #(
  parameter int NUM_CPU  = 4,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [NUM_CPU-1:0]              cpu_req,
  input  logic [NUM_CPU-1:0]              cpu_write,
  input  logic [NUM_CPU*ADDR_W-1:0]       cpu_addr,
  input  logic [NUM_CPU*DATA_W-1:0]       cpu_data_in,
  input  logic [NUM_CPU*(DATA_W/8)-1:0]   cpu_byteenable,
  output logic [NUM_CPU-1:0]              cpu_ready,
  output logic [NUM_CPU*DATA_W-1:0]       cpu_data_out,
  output logic                            busy,
  output logic [ADDR_W-1:0]               pcm_mem_mm_address,
  output logic                            pcm_mem_mm_chipselect,
  output logic                            pcm_mem_mm_clken,
  output logic                            pcm_mem_mm_write,
  output logic [DATA_W-1:0]               pcm_mem_mm_writedata,
  output logic [DATA_W/8-1:0]             pcm_mem_mm_byteenable,
  input  logic [DATA_W-1:0]               pcm_mem_mm_readdata
);

  localparam int GW   = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] gnt_sel;
  logic [2:0]    lat_cnt;
  logic          any_req;

  assign any_req = |cpu_req;

`ifdef PCM_MM_ROUND_ROBIN_EN
  logic [GW-1:0] ptr;
  logic [GW:0]   idx;
  logic          found;

  // Scan starts at the pointer and wraps modulo NUM_CPU.
  always_comb begin
    gnt_sel = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      idx = {1'b0, ptr} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_CPU)) idx = idx - (GW+1)'(NUM_CPU);
      if (!found && cpu_req[idx[GW-1:0]]) begin
        found   = 1'b1;
        gnt_sel = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (init) begin
      ptr <= '0;
    end else if (state == IDLE && any_req) begin
      ptr <= (gnt_sel == GW'(NUM_CPU - 1)) ? '0 : gnt_sel + GW'(1);
    end
  end
`else
  always_comb begin
    gnt_sel = '0;
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      if (cpu_req[k]) gnt_sel = GW'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      grant                 <= '0;
      lat_cnt               <= '0;
      busy                  <= 1'b0;
      cpu_ready             <= '0;
      cpu_data_out          <= '0;
      pcm_mem_mm_address    <= '0;
      pcm_mem_mm_chipselect <= 1'b0;
      pcm_mem_mm_clken      <= 1'b0;
      pcm_mem_mm_write      <= 1'b0;
      pcm_mem_mm_writedata  <= '0;
      pcm_mem_mm_byteenable <= '0;
    end else if (init) begin
      // Abandons any in-flight transaction; its channel never sees ready.
      state                 <= IDLE;
      lat_cnt               <= '0;
      busy                  <= 1'b0;
      cpu_ready             <= '0;
      cpu_data_out          <= '0;
      pcm_mem_mm_chipselect <= 1'b0;
      pcm_mem_mm_clken      <= 1'b0;
      pcm_mem_mm_write      <= 1'b0;
    end else begin
      cpu_ready <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant                 <= gnt_sel;
            pcm_mem_mm_address    <= cpu_addr[gnt_sel*ADDR_W +: ADDR_W];
            pcm_mem_mm_writedata  <= cpu_data_in[gnt_sel*DATA_W +: DATA_W];
            pcm_mem_mm_byteenable <= cpu_byteenable[gnt_sel*BE_W +: BE_W];
            pcm_mem_mm_write      <= cpu_write[gnt_sel];
            pcm_mem_mm_chipselect <= 1'b1;
            pcm_mem_mm_clken      <= 1'b1;
            busy                  <= 1'b1;
            state                 <= ISSUE;
          end
        end
        ISSUE: begin
          pcm_mem_mm_chipselect <= 1'b0;
          pcm_mem_mm_write      <= 1'b0;
          if (pcm_mem_mm_write) begin
            pcm_mem_mm_clken <= 1'b0;
            cpu_ready        <= NUM_CPU'(1) << grant;
            state            <= DONE;
          end else begin
            lat_cnt <= 3'(READ_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            cpu_data_out[grant*DATA_W +: DATA_W] <= pcm_mem_mm_readdata;
            pcm_mem_mm_clken <= 1'b0;
            cpu_ready        <= NUM_CPU'(1) << grant;
            state            <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_mm_arbiter.sv
// tb/tb_pcm_mm_arbiter.sv - directed, scoreboard-checked bench for pcm_mm_arbiter
// Checks follow PCM_MM_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_pcm_mm_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int L  = 1;

  logic            clk, reset, init;
  logic [N-1:0]    cpu_req, cpu_write;
  logic [N*AW-1:0] cpu_addr;
  logic [N*DW-1:0] cpu_data_in;
  logic [N*2-1:0]  cpu_byteenable;
  logic [DW-1:0]   rd1, rd3;

  logic [N-1:0]    ready1, ready3;
  logic [N*DW-1:0] dout1, dout3;
  logic            busy1, busy3, cs1, cs3, ck1, ck3, wr1, wr3;
  logic [AW-1:0]   addr1, addr3;
  logic [DW-1:0]   wd1, wd3;
  logic [1:0]      be1, be3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt;

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  pcm_mm_arbiter #(.NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(L)) dut (
    .clk(clk), .reset(reset), .init(init),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_byteenable(cpu_byteenable),
    .cpu_ready(ready1), .cpu_data_out(dout1), .busy(busy1),
    .pcm_mem_mm_address(addr1), .pcm_mem_mm_chipselect(cs1), .pcm_mem_mm_clken(ck1),
    .pcm_mem_mm_write(wr1), .pcm_mem_mm_writedata(wd1), .pcm_mem_mm_byteenable(be1),
    .pcm_mem_mm_readdata(rd1)
  );

  pcm_mm_arbiter #(.NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .init(init),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_byteenable(cpu_byteenable),
    .cpu_ready(ready3), .cpu_data_out(dout3), .busy(busy3),
    .pcm_mem_mm_address(addr3), .pcm_mem_mm_chipselect(cs3), .pcm_mem_mm_clken(ck3),
    .pcm_mem_mm_write(wr3), .pcm_mem_mm_writedata(wd3), .pcm_mem_mm_byteenable(be3),
    .pcm_mem_mm_readdata(rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int ch, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] be);
    cpu_write[ch]            = wr;
    cpu_addr[ch*AW +: AW]    = a;
    cpu_data_in[ch*DW +: DW] = d;
    cpu_byteenable[ch*2 +: 2] = be;
    cpu_req[ch]              = 1'b1;
  endtask

  task automatic rd_txn(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd1 = d;
    start(ch, 1'b0, a, 16'h0000, 2'b11);
    q.push_back('{ch, d, cyc + 2 + L});
    tick();
    check("rd_issue_addr", addr1, a);
    check("rd_issue_cs", cs1, 1'b1);
    check("rd_issue_write", wr1, 1'b0);
    check("rd_issue_clken", ck1, 1'b1);
    tick();
    check("rd_wait_cs", cs1, 1'b0);
    check("rd_wait_clken", ck1, 1'b1);
    repeat (L) tick();
    cpu_req[ch] = 1'b0;
    tick();
    check("rd_idle_busy", busy1, 1'b0);
  endtask

  task automatic wr_txn(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] be, input logic [DW-1:0] keep);
    start(ch, 1'b1, a, d, be);
    q.push_back('{ch, keep, cyc + 2});
    tick();
    check("wr_issue_addr", addr1, a);
    check("wr_issue_cs", cs1, 1'b1);
    check("wr_issue_write", wr1, 1'b1);
    check("wr_issue_wdata", wd1, d);
    check("wr_issue_be", be1, be);
    tick();
    check("wr_done_cs", cs1, 1'b0);
    cpu_req[ch] = 1'b0;
    tick();
    check("wr_idle_busy", busy1, 1'b0);
  endtask

  // Scoreboard: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && ready1 !== '0) begin
      if (q.size() == 0) begin
        check("unexpected_ready", ready1, 0);
      end else begin
        e = q.pop_front();
        check("ready_vec", ready1, 4'b0001 << e.ch);
        check("ready_cycle", cyc, e.cyc);
        check("data_out", dout1[e.ch*DW +: DW], e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; init = 1'b0;
    cpu_req = '0; cpu_write = '0; cpu_addr = '0; cpu_data_in = '0; cpu_byteenable = '0;
    rd1 = '0; rd3 = '0;
    #2 reset = 1'b0;
    #2;
    check("rst_busy", busy1, 1'b0);
    check("rst_ready", ready1, '0);
    check("rst_cs", cs1, 1'b0);
    check("rst_clken", ck1, 1'b0);
    check("rst_addr", addr1, '0);
    check("rst_dout", dout1, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    init = 1'b1;
    tick();
    init = 1'b0;

    rd_txn(0, 20'h00606, 16'h0909);
    rd_txn(2, 20'h00042, 16'h5A5A);
    wr_txn(2, 20'hABCDE, 16'h1234, 2'b10, 16'h5A5A);

    // Contention: all channels request continuously.
    init = 1'b1;
    tick();
    init = 1'b0;
    rd1 = 16'hC0DE;
    for (int k = 0; k < N; k++) start(k, 1'b0, AW'(k * 16'h100), 16'h0000, 2'b11);
    for (int k = 0; k < 5; k++) begin
`ifdef PCM_MM_ROUND_ROBIN_EN
      q.push_back('{k % N, 16'hC0DE, cyc + 3 + 4 * k});
`else
      q.push_back('{0, 16'hC0DE, cyc + 3 + 4 * k});
`endif
    end
    cnt = 0;
    for (int n = 0; n < 40 && cnt < 5; n++) begin
      tick();
      if (ready1 != '0) begin
        cnt++;
        if (cnt == 5) cpu_req = '0;
      end
    end
    check("contention_readies", cnt, 5);
    tick();

    // Asynchronous reset in the middle of a read.
    rd1 = 16'h3333;
    start(3, 1'b0, 20'h33333, 16'h0000, 2'b11);
    tick();
    tick();
    check("pre_rst_clken", ck1, 1'b1);
    check("pre_rst_busy", busy1, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_cs", cs1, 1'b0);
    check("arst_clken", ck1, 1'b0);
    check("arst_busy", busy1, 1'b0);
    check("arst_ready", ready1, '0);
    check("arst_dout", dout1, '0);
    cpu_req = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    rd1 = 16'h4444;
    start(0, 1'b0, 20'h00AAA, 16'h0000, 2'b11);
    start(3, 1'b0, 20'h00BBB, 16'h0000, 2'b11);
    q.push_back('{0, 16'h4444, cyc + 3});
    q.push_back('{3, 16'h4444, cyc + 7});
    tick();
    check("post_rst_grant_addr", addr1, 20'h00AAA);
    tick();
    tick();
    cpu_req[0] = 1'b0;
    repeat (4) tick();
    cpu_req[3] = 1'b0;
    tick();

    // Soft clear during WAIT; request still held so it is served again.
    rd1 = 16'h7777;
    start(1, 1'b0, 20'h11111, 16'h0000, 2'b11);
    tick();
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    check("init_busy", busy1, 1'b0);
    check("init_ready", ready1, '0);
    check("init_dout", dout1, '0);
    q.push_back('{1, 16'h7777, cyc + 3});
    repeat (3) tick();
    cpu_req[1] = 1'b0;
    tick();

    // Read latency 3 with a slave whose readdata advances every cycle.
    init = 1'b1;
    tick();
    init = 1'b0;
    rd1 = 16'hBEEF;
    start(1, 1'b0, 20'h22222, 16'h0000, 2'b11);
    q.push_back('{1, 16'hBEEF, cyc + 3});
    tick();
    rd3 = 16'h0100;
    check("lat3_issue_cs", cs3, 1'b1);
    tick();
    rd3 = 16'h0101;
    tick();
    rd3 = 16'h0102;
    cpu_req[1] = 1'b0;
    tick();
    rd3 = 16'h0103;
    check("lat3_early_ready", ready3, '0);
    check("lat3_wait_busy", busy3, 1'b1);
    tick();
    rd3 = 16'h0104;
    check("lat3_ready", ready3, 4'b0010);
    check("lat3_data", dout3[DW +: DW], 16'h0103);
    tick();
    check("lat3_idle_busy", busy3, 1'b0);

    repeat (2) tick();
    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_mm_arbiter.md
# pcm_mm_arbiter

Parametrised N-channel arbiter between CPU request ports and the single `pcm_mem_mm` memory-mapped slave port. It supersedes the fixed four-CPU, fixed-width `PCM_MM` datapath and adds:
- an explicit request/ready handshake per channel;
- per-channel byte enables;
- a configurable slave read latency;
- selectable round-robin or fixed-priority arbitration.

One transaction is in flight at a time.

## Interface
- NUM_CPU, 4, number of requesting channels (2..8)
- ADDR_W, 20, address width
- DATA_W, 16, data width; multiple of 8
- READ_LAT, 1, cycles from the slave issue cycle to valid `pcm_mem_mm_readdata` (1..4)

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- init  in  1  synchronous soft clear, active high
- cpu_req  in  NUM_CPU  per-channel request level
- cpu_write  in  NUM_CPU  1 = write, 0 = read
- cpu_addr  in  NUM_CPU*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- cpu_data_in  in  NUM_CPU*DATA_W  packed write data
- cpu_byteenable  in  NUM_CPU*DATA_W/8  packed byte enables
- cpu_ready  out  NUM_CPU  one-cycle completion pulse per channel
- cpu_data_out  out  NUM_CPU*DATA_W  per-channel last read data
- busy  out  1  high whenever the FSM is not IDLE
- pcm_mem_mm_address  out  ADDR_W  slave address
- pcm_mem_mm_chipselect  out  1  slave select
- pcm_mem_mm_clken  out  1  slave clock enable
- pcm_mem_mm_write  out  1  slave write strobe
- pcm_mem_mm_writedata  out  DATA_W  slave write data
- pcm_mem_mm_byteenable  out  DATA_W/8  slave byte enables
- pcm_mem_mm_readdata  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `cpu_req` bit is set: select a grant, latch that channel's write/addr/data/byteenable into internal registers, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - Drives from the latched registers: chipselect=1, clken=1, write=latched write, address, writedata, byteenable.
  - Write → DONE. Read → WAIT, with the latency counter loaded to READ_LAT.
- **WAIT**
  - chipselect=0, clken=1; counter decrements each cycle.
  - On the edge ending the READ_LAT-th WAIT cycle: capture `pcm_mem_mm_readdata` into the granted channel's `cpu_data_out`, go to DONE.
- **DONE** (1 cycle)
  - `cpu_ready[grant]`=1, then go to IDLE.
  - `cpu_req` is not sampled in DONE.
- CPU-side handshake:
  - Hold req and all fields stable from req assertion until ready is seen.
  - Deassert req on the edge ending the DONE cycle.
  - A req still high in the following IDLE cycle is a new transaction.
- `cpu_data_out[i]` updates only on channel i read completion; writes leave it unchanged.
- Address, data and byte enables pass through unmodified; no width conversion.
- `init` high on any edge:
  - FSM to IDLE; all cpu_ready, chipselect, write and clken low next cycle.
  - Round-robin pointer to 0; all cpu_data_out cleared.
  - Any in-flight transaction is abandoned and never gets a ready.
- Reset values (reset low, asynchronous, immediate): every output 0, FSM IDLE, pointer 0, latched registers 0.

## Timing
- Req first seen in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - Write: ready at cycle 2.
  - Read: ready at cycle 2+READ_LAT, with data valid on `cpu_data_out` in that same cycle.
- Throughput per transaction: write 3 cycles; read 3+READ_LAT cycles (IDLE cycle included).
- Slave outputs are registered; slave inputs are sampled only in WAIT.
- Simultaneous `init` and an active state: `init` wins.
- `reset` overrides `init`.
- `busy` = (state != IDLE), registered.

## Configuration
- Macro: `PCM_MM_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - Search starts at the pointer and wraps modulo NUM_CPU.
  - After each grant, pointer = grant+1, wrapping NUM_CPU-1 → 0.
- **Undefined:** fixed priority; lowest requesting index wins; no pointer register.

## Test plan
- **Basic read:** init pulse, then cpu0 reads 0x00606 with readdata=0x0909, READ_LAT=1 → cycle 1: address=0x00606, chipselect=1, write=0; cycle 3: cpu_ready[0]=1 and cpu_data_out[0]=0x0909; all other channels' ready stay 0.
- **Write:** cpu2 writes addr 0xABCDE, data 0x1234, byteenable 2'b10 → one cycle of chipselect=1, write=1, writedata=0x1234, byteenable=2'b10; cpu_ready[2] at cycle 2; cpu_data_out[2] unchanged.
- **Contention:** all four reqs held high, each re-asserting after its ready.
  - With the macro: grant order 0, 1, 2, 3, 0.
  - Without the macro: grants 0, 0, 0 and channels 1–3 never get ready.
- **Latency:** READ_LAT=3, readdata increments every cycle from 0x0100 starting at ISSUE → captured value is 0x0103; ready arrives 5 cycles after the IDLE sample.
- **Async reset:** reset driven low mid-WAIT → chipselect, clken, busy and all cpu_ready go 0 without waiting for a clock edge; after release, no ready for the aborted read and the next grant starts at cpu0.
- **Init during WAIT:** init high for one cycle during WAIT → next cycle busy=0 and cpu_data_out all 0; the aborted channel gets no ready and is re-served only if its req is still high.
